// File: rtl/nibble_serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_adder_pkg
// Brief    : Shared types and constants for the nibble-serial adder.
// Revision : 1.0 - initial release
// ============================================================================
package nibble_serial_adder_pkg;

  // Width of one time-multiplexed adder slice.
  localparam int SLICE_W = 4;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : nibble_serial_adder_pkg
`default_nettype wire

// File: rtl/nibble_serial_adder_if.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_adder_if
// Brief    : Operand / result handshake bundle for the nibble-serial adder.
// Revision : 1.0 - initial release
// ============================================================================
interface nibble_serial_adder_if #(
  parameter int WIDTH = 16
);

  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             result_valid;
  logic             result_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;

  // Requester side: presents operands, consumes results.
  modport master (
    output start_valid, a, b, cin, result_ready,
    input  start_ready, result_valid, sum, cout, ovf, busy
  );

  // Adder side.
  modport slave (
    input  start_valid, a, b, cin, result_ready,
    output start_ready, result_valid, sum, cout, ovf, busy
  );

endinterface : nibble_serial_adder_if
`default_nettype wire

// File: rtl/nibble_serial_adder_cla4_slice.sv
`default_nettype none
// ============================================================================
// Module   : cla4_slice
// Brief    : 4-bit carry-lookahead adder slice; also exposes the carry into
//            bit 3 so the caller can derive two's-complement overflow.
// Revision : 1.0 - initial release
// ============================================================================
module cla4_slice (
  input  wire logic [3:0] a,
  input  wire logic [3:0] b,
  input  wire logic       ci,
  output logic      [3:0] s,
  output logic            co,
  output logic            c3
);

  logic [3:0] w_g;
  logic [3:0] w_p;
  logic       w_c1;
  logic       w_c2;
  logic       w_c3;
  logic       w_c4;

  assign w_g = a & b;
  assign w_p = a ^ b;

  // Flat lookahead equations: every carry is two logic levels from the inputs.
  assign w_c1 = w_g[0] | (w_p[0] & ci);
  assign w_c2 = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & ci);
  assign w_c3 = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
              | (w_p[2] & w_p[1] & w_p[0] & ci);
  assign w_c4 = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
              | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
              | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & ci);

  assign s  = w_p ^ {w_c3, w_c2, w_c1, ci};
  assign co = w_c4;
  assign c3 = w_c3;

endmodule : cla4_slice
`default_nettype wire

// File: rtl/nibble_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_adder
// Brief    : WIDTH-bit adder that processes one 4-bit slice per clock through
//            a single shared lookahead slice, with valid/ready handshakes.
// Revision : 1.0 - initial release
// ============================================================================
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  nibble_serial_adder_if.slave  bus
);

  localparam int             NIB    = WIDTH / SLICE_W;
  localparam int             KW     = $clog2(NIB) + 1;
  localparam logic [KW-1:0]  LAST_K = KW'(NIB - 1);

  state_t              state_q;
  logic [KW-1:0]       k_q;
  logic                carry_q;
  logic [WIDTH-1:0]    a_q;
  logic [WIDTH-1:0]    b_q;
  logic [WIDTH-1:0]    sum_q;
  logic                cout_q;
  logic                ovf_q;

  logic [SLICE_W-1:0]  w_sa;
  logic [SLICE_W-1:0]  w_sb;
  logic [SLICE_W-1:0]  w_s;
  logic                w_co;
  logic                w_c3;

  // Select the operand slices addressed by the current nibble index.
  always_comb begin
    w_sa = '0;
    w_sb = '0;
    for (int i = 0; i < NIB; i++) begin
      if (k_q == KW'(i)) begin
        w_sa = a_q[i*SLICE_W +: SLICE_W];
        w_sb = b_q[i*SLICE_W +: SLICE_W];
      end
    end
  end

  cla4_slice u_slice (
    .a  (w_sa),
    .b  (w_sb),
    .ci (carry_q),
    .s  (w_s),
    .co (w_co),
    .c3 (w_c3)
  );

  // Sequencer: capture operands, add one slice per edge, hold result until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start_valid) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            carry_q <= bus.cin;
            k_q     <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          for (int i = 0; i < NIB; i++) begin
            if (k_q == KW'(i)) begin
              sum_q[i*SLICE_W +: SLICE_W] <= w_s;
            end
          end
          carry_q <= w_co;
          k_q     <= k_q + 1'b1;
          if (k_q == LAST_K) begin
            // Overflow: carry into the sign bit differs from carry out of it.
            cout_q  <= w_co;
            ovf_q   <= w_c3 ^ w_co;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (bus.result_ready) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Handshake flags decode straight from the state register.
  assign bus.start_ready  = (state_q == IDLE);
  assign bus.busy         = (state_q != IDLE);
  assign bus.result_valid = (state_q == DONE);
  assign bus.sum          = sum_q;
  assign bus.cout         = cout_q;
  assign bus.ovf          = ovf_q;

endmodule : nibble_serial_adder
`default_nettype wire
